// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if
//   Bundle of the writeback request bus and the register-file write port
//   served by wb_port_arbiter.
//   i_hold       : write port unavailable this cycle
//   i_req_valid  : per-requester write request
//   i_req_addr   : packed destination addresses, requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   i_req_data   : packed write data, same packing
//   o_req_ready  : combinational one-hot (or zero) accept
//   o_rf_we/o_rf_waddr/o_rf_wdata : registered register-file write
//   o_grant      : registered one-hot id of the staged requester
//   modport master : arbiter side (drives o_*)
//   modport slave  : requester / register-file side (drives i_*)
interface wb_port_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
);
   logic                         i_hold;
   logic [NUM_REQ-1:0]           i_req_valid;
   logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr;
   logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data;
   logic [NUM_REQ-1:0]           o_req_ready;
   logic                         o_rf_we;
   logic [ADDR_WIDTH-1:0]        o_rf_waddr;
   logic [DATA_WIDTH-1:0]        o_rf_wdata;
   logic [NUM_REQ-1:0]           o_grant;

   modport master (
      input  i_hold, i_req_valid, i_req_addr, i_req_data,
      output o_req_ready, o_rf_we, o_rf_waddr, o_rf_wdata, o_grant
   );

   modport slave (
      output i_hold, i_req_valid, i_req_addr, i_req_data,
      input  o_req_ready, o_rf_we, o_rf_waddr, o_rf_wdata, o_grant
   );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Round-robin arbiter sharing the single integer register-file write port
//   between NUM_REQ writeback requesters. At most one request is accepted per
//   cycle; the winner's address/data are registered into a one-cycle output
//   stage. Writes to r0 are consumed but do not assert o_rf_we.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : request bus and register-file write port (wb_port_arbiter_if.master)
module wb_port_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input logic                clk,
   input logic                rst_n,
   wb_port_arbiter_if.master  bus
);
   localparam int PTR_WIDTH = $clog2(NUM_REQ);

   logic [PTR_WIDTH-1:0]  rr_ptr;
   logic [PTR_WIDTH-1:0]  win_idx;
   logic                  win_found;
   logic [NUM_REQ-1:0]    ready;
   logic [ADDR_WIDTH-1:0] win_addr;
   logic [DATA_WIDTH-1:0] win_data;
   int unsigned           k;

   // Scan requesters starting at rr_ptr with wrap-around; first valid wins.
   // Ready is suppressed during reset so nothing is consumed in that cycle.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      ready     = '0;
      k         = '0;
      if (rst_n && !bus.i_hold) begin
         for (int unsigned i = 0; i < unsigned'(NUM_REQ); i++) begin
            k = 32'(rr_ptr) + i;
            if (k >= unsigned'(NUM_REQ)) k = k - unsigned'(NUM_REQ);
            if (!win_found && bus.i_req_valid[PTR_WIDTH'(k)]) begin
               win_found = 1'b1;
               win_idx   = PTR_WIDTH'(k);
            end
         end
      end
      if (win_found) ready[win_idx] = 1'b1;
   end

   assign win_addr        = bus.i_req_addr[32'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
   assign win_data        = bus.i_req_data[32'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
   assign bus.o_req_ready = ready;

   // A transfer is exactly win_found: the winner is valid and ready by construction.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr         <= '0;
         bus.o_rf_we    <= 1'b0;
         bus.o_rf_waddr <= '0;
         bus.o_rf_wdata <= '0;
         bus.o_grant    <= '0;
      end else begin
         bus.o_rf_we <= win_found && (win_addr != '0);
         bus.o_grant <= ready;
         if (win_found) begin
            bus.o_rf_waddr <= win_addr;
            bus.o_rf_wdata <= win_data;
            rr_ptr         <= (32'(win_idx) == NUM_REQ - 1) ? '0 : PTR_WIDTH'(win_idx + 1'b1);
         end
      end
   end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Round-robin arbiter that shares the single integer register-file write port between multiple writeback requesters (e.g. ALU, MUL, DIV, LSU). It selects at most one request per cycle and registers the winning address/data into a one-cycle output stage that drives the register file. It suppresses writes to r0. A hold input lets a higher-priority agent take the port.

## Interface
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ADDR_WIDTH, 5, register address width.
- DATA_WIDTH, 32, write data width.
- PTR_WIDTH, $clog2(NUM_REQ), round-robin pointer width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- i_hold  in  1  write port unavailable this cycle; no grant issued.
- i_req_valid  in  NUM_REQ  per-requester write request.
- i_req_addr  in  NUM_REQ*ADDR_WIDTH  packed destination addresses; requester k at [k*ADDR_WIDTH +: ADDR_WIDTH].
- i_req_data  in  NUM_REQ*DATA_WIDTH  packed write data, same packing.
- o_req_ready  out  NUM_REQ  one-hot (or zero) combinational accept.
- o_rf_we  out  1  registered register-file write enable.
- o_rf_waddr  out  ADDR_WIDTH  registered write address.
- o_rf_wdata  out  DATA_WIDTH  registered write data.
- o_grant  out  NUM_REQ  registered one-hot id of the requester whose data is on the output stage.

## Operation
- State: rr_ptr (PTR_WIDTH), output stage regs {o_rf_we, o_rf_waddr, o_rf_wdata, o_grant}.
- Arbitration (combinational): if i_hold=0, the winner g is the first k with i_req_valid[k]=1, scanning k = rr_ptr, rr_ptr+1, ..., wrapping NUM_REQ-1 -> 0. o_req_ready[g]=1; all other ready bits are 0. No valid or i_hold=1 -> o_req_ready=0.
- Transfer occurs when i_req_valid[k] & o_req_ready[k]. A requester holds valid/addr/data stable until it sees ready. Valid does not depend on ready.
- On transfer: rr_ptr <= (g==NUM_REQ-1) ? 0 : g+1. Without a transfer, rr_ptr holds.
- Output stage, every cycle: o_rf_we <= transfer & (addr_g != 0); o_rf_waddr <= addr_g; o_rf_wdata <= data_g; o_grant <= one-hot(g) on transfer, else 0.
- With no transfer, o_rf_waddr/o_rf_wdata hold their previous values. Only o_rf_we and o_grant clear.
- An r0 write is consumed (ready=1, o_grant set) but o_rf_we=0.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles in which i_hold=0.

## Timing
- Reset (rst_n=0 at a clk edge): rr_ptr=0, o_rf_we=0, o_rf_waddr=0, o_rf_wdata=0, o_grant=0. o_req_ready is 0 while rst_n=0.
- Latency: transfer in cycle t -> o_rf_we/waddr/wdata/o_grant valid in cycle t+1 for exactly one cycle.
- Throughput: one write per cycle. Back-to-back grants to different requesters are allowed, as are back-to-back grants to the same sole requester.
- i_hold=1 in cycle t: no transfer in t, rr_ptr frozen, o_rf_we=0 in t+1. The output stage captured in t-1 still appears in t regardless of i_hold.
- Reset asserted mid-stream: a request pending in the reset cycle is not accepted and must be re-presented. A staged write is dropped (o_rf_we=0 next cycle).
- Simultaneous valid on all requesters: grants rotate in order starting at rr_ptr.

## Test plan
- Reset, then req0 valid, addr=3, data=0xDEADBEEF -> ready[0]=1 same cycle; next cycle o_rf_we=1, waddr=3, wdata=0xDEADBEEF, o_grant=4'b0001; rr_ptr=1.
- All four valid continuously, 8 cycles, rr_ptr=0 at start -> grant order 0,1,2,3,0,1,2,3, one per cycle; o_rf_we=1 every cycle from cycle 1.
- req2 valid addr=0 data=0x5 -> ready[2]=1; next cycle o_rf_we=0, o_grant=4'b0100; rr_ptr=3.
- rr_ptr=2, req1 and req3 valid, i_hold=1 for 2 cycles -> no ready, o_rf_we=0, rr_ptr stays 2. Hold released -> req3 granted, then req1.
- Only req3 valid, rr_ptr=0 -> req3 granted, rr_ptr wraps to 0; req3 valid again next cycle -> granted again (back-to-back).
- req1 pending with rr_ptr=1, rst_n=0 for one cycle -> no ready during reset, next cycle o_rf_we=0, rr_ptr=0. After release, req1 granted.
